// File: rtl/menu_hop_row.sv
// menu_hop_row: renders a row of N_CUBES isometric cubes and one hopping
// character for the title menu. It sits between the VGA pixel counters and
// the menu/game RGB multiplexer.
//
// The character hops one cube per accepted JPulse:
//   rise (x decreases) -> slide (y changes by one cube pitch) -> fall -> land.
// Each landing advances the top-face colour of the landed cube.
// level_done is high while every cube shows the final colour.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-low reset
//   JPulse     one-cycle hop request
//   dir        0: hop toward +y (idx+1), 1: hop toward -y (idx-1)
//   x_cnt      current pixel x
//   y_cnt      current pixel y
//   menu_RGB   pixel colour, registered, 2 cycles after x_cnt/y_cnt
//   hop_busy   hop in progress
//   pos_idx    cube currently occupied
//   level_done all cubes at colour N_COLORS-1
//   state_dbg  current hop FSM state (debug visibility)
//
// Request handshake: JPulse acts as a valid strobe. The block is ready only
// while hop_busy=0 (IDLE). A request is accepted on the clock edge where
// JPulse=1, the FSM is IDLE and the target cube exists. dir is sampled only
// on that edge. Any other JPulse is dropped and is not queued.
module menu_hop_row #(
  parameter int N_CUBES       = 4,
  parameter int N_COLORS      = 5,
  parameter int COLOR_WRAP    = 0,
  parameter int START_IDX     = 0,
  parameter int STEP_DIV_LOG2 = 17,
  parameter int X0            = 350,
  parameter int Y0            = 110,
  parameter int CUBE_PITCH    = 200,
  parameter int XLEN          = 100,
  parameter int XDIAG         = 80,
  parameter int YDIAG         = 100,
  parameter int HOP_HEIGHT    = 100
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        JPulse,
  input  logic                        dir,
  input  logic [10:0]                 x_cnt,
  input  logic [9:0]                  y_cnt,
  output logic [23:0]                 menu_RGB,
  output logic                        hop_busy,
  output logic [$clog2(N_CUBES)-1:0]  pos_idx,
  output logic                        level_done,
  output logic [2:0]                  state_dbg
);

  localparam int IW = $clog2(N_CUBES);
  localparam int CW = $clog2(N_COLORS);

  localparam logic [23:0] BG_RGB    = {8'd146, 8'd165, 8'd216};
  localparam logic [23:0] CHAR_RGB  = {8'd216, 8'd95,  8'd2};
  localparam logic [23:0] RIGHT_RGB = {8'd49,  8'd70,  8'd70};
  localparam logic [23:0] LEFT_RGB  = {8'd86,  8'd169, 8'd152};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RISE  = 3'd1,
    ST_SLIDE = 3'd2,
    ST_FALL  = 3'd3,
    ST_LAND  = 3'd4
  } state_t;

  function automatic logic [23:0] palette(input logic [2:0] ci);
    logic [23:0] c;
    case (ci)
      3'd0:    c = {8'd222, 8'd222, 8'd0};
      3'd1:    c = {8'd86,  8'd70,  8'd239};
      3'd2:    c = {8'd0,   8'd255, 8'd64};
      3'd3:    c = {8'd132, 8'd35,  8'd156};
      3'd4:    c = {8'd170, 8'd13,  8'd40};
      3'd5:    c = {8'd255, 8'd255, 8'd255};
      3'd6:    c = {8'd255, 8'd128, 8'd0};
      default: c = {8'd0,   8'd200, 8'd200};
    endcase
    return c;
  endfunction

  // ---------------------------------------------------------------------
  // Hop FSM and motion datapath
  // ---------------------------------------------------------------------
  state_t                   state, state_next;
  logic [STEP_DIV_LOG2-1:0] tick_cnt;
  logic [15:0]              step_cnt;
  logic [11:0]              xc, yc;
  logic [IW-1:0]            tgt_idx;
  logic                     hop_dir;
  logic [CW-1:0]            color_idx  [N_CUBES];
  logic [CW-1:0]            color_next [N_CUBES];
  logic                     done_next;
  logic                     tick;
  logic                     target_ok;
  logic                     accept;
  logic                     phase_end;

  assign tick = (tick_cnt == '1);

  always_comb begin
    target_ok = 1'b1;
    if (dir && (pos_idx == '0))
      target_ok = 1'b0;
    if (!dir && (pos_idx == IW'(N_CUBES - 1)))
      target_ok = 1'b0;
  end

  // phase_end marks the last tick of the current motion phase.
  always_comb begin
    phase_end = 1'b0;
    case (state)
      ST_RISE:  phase_end = tick && (step_cnt == 16'(HOP_HEIGHT - 1));
      ST_SLIDE: phase_end = tick && (step_cnt == 16'(CUBE_PITCH - 1));
      ST_FALL:  phase_end = tick && (step_cnt == 16'(HOP_HEIGHT - 1));
      default:  phase_end = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (JPulse && target_ok) begin
          accept     = 1'b1;
          state_next = ST_RISE;
        end
      end
      ST_RISE:  if (phase_end) state_next = ST_SLIDE;
      ST_SLIDE: if (phase_end) state_next = ST_FALL;
      ST_FALL:  if (phase_end) state_next = ST_LAND;
      ST_LAND:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  assign hop_busy  = (state != ST_IDLE);
  assign state_dbg = state;

  // Colour update of the landed cube; level_done is computed from the
  // post-update indices so it is valid in the cycle right after LAND.
  always_comb begin
    for (int k = 0; k < N_CUBES; k++)
      color_next[k] = color_idx[k];
    if (state == ST_LAND) begin
      if (color_idx[tgt_idx] == CW'(N_COLORS - 1)) begin
        if (COLOR_WRAP != 0)
          color_next[tgt_idx] = '0;
      end else begin
        color_next[tgt_idx] = color_idx[tgt_idx] + CW'(1);
      end
    end
    done_next = 1'b1;
    for (int k = 0; k < N_CUBES; k++)
      if (color_next[k] != CW'(N_COLORS - 1))
        done_next = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt   <= '0;
      step_cnt   <= '0;
      xc         <= 12'(X0);
      yc         <= 12'(Y0 + YDIAG + START_IDX * CUBE_PITCH);
      pos_idx    <= IW'(START_IDX);
      tgt_idx    <= IW'(START_IDX);
      hop_dir    <= 1'b0;
      level_done <= 1'b0;
      for (int k = 0; k < N_CUBES; k++)
        color_idx[k] <= '0;
    end else begin
      level_done <= done_next;
      for (int k = 0; k < N_CUBES; k++)
        color_idx[k] <= color_next[k];
      if (accept) begin
        tick_cnt <= '0;
        step_cnt <= '0;
        hop_dir  <= dir;
        tgt_idx  <= dir ? (pos_idx - IW'(1)) : (pos_idx + IW'(1));
      end else if (state == ST_RISE || state == ST_SLIDE || state == ST_FALL) begin
        tick_cnt <= tick_cnt + 1'b1;
        if (tick) begin
          step_cnt <= phase_end ? 16'd0 : (step_cnt + 16'd1);
          case (state)
            ST_RISE:  xc <= xc - 12'd1;
            ST_SLIDE: yc <= hop_dir ? (yc - 12'd1) : (yc + 12'd1);
            ST_FALL:  xc <= xc + 12'd1;
            default:  xc <= xc;
          endcase
        end
      end else if (state == ST_LAND) begin
        pos_idx <= tgt_idx;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Pixel pipeline, stage 1: region classification
  // ---------------------------------------------------------------------
  logic          char_c, right_c, left_c, top_c;
  logic [IW-1:0] cube_c;
  logic          s1_char, s1_right, s1_left, s1_top;
  logic [IW-1:0] s1_cube;

  always_comb begin
    int px, py, xci, yci, yk, adx, ady, lr, ll;
    logic body, snout, feet;
    px  = int'(x_cnt);
    py  = int'(y_cnt);
    xci = int'(xc);
    yci = int'(yc);
    body  = (px >= xci - XDIAG / 2) && (px <= xci + XDIAG / 3) &&
            (py >= yci - YDIAG / 4) && (py <= yci + YDIAG / 4);
    snout = (px >= xci - XDIAG / 4) && (px <= xci + XDIAG / 3) &&
            (py >  yci + YDIAG / 4) && (py <= yci + 2 * YDIAG / 3);
    feet  = (px >= xci + XDIAG / 3) && (px <= xci + 2 * XDIAG / 3) &&
            (py >= yci - YDIAG / 6) && (py <= yci + YDIAG / 6);
    char_c  = body || snout || feet;
    right_c = 1'b0;
    left_c  = 1'b0;
    top_c   = 1'b0;
    cube_c  = '0;
    yk  = 0;
    adx = 0;
    ady = 0;
    lr  = 0;
    ll  = 0;
    // Descending scan so the lowest-numbered cube wins a shared top edge.
    for (int k = N_CUBES - 1; k >= 0; k--) begin
      yk  = Y0 + k * CUBE_PITCH;
      adx = (px >= X0) ? (px - X0) : (X0 - px);
      ady = (py >= yk + YDIAG) ? (py - yk - YDIAG) : (yk + YDIAG - py);
      if (adx * YDIAG + ady * XDIAG <= XDIAG * YDIAG) begin
        top_c  = 1'b1;
        cube_c = IW'(k);
      end
      if ((py >= yk) && (py < yk + YDIAG)) begin
        lr = X0 + (py - yk) * XDIAG / YDIAG;
        if ((px >= lr) && (px <= lr + XLEN))
          right_c = 1'b1;
      end
      if ((py >= yk + YDIAG) && (py <= yk + 2 * YDIAG)) begin
        ll = X0 + XDIAG - (py - yk - YDIAG) * XDIAG / YDIAG;
        if ((px >= ll) && (px <= ll + XLEN))
          left_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_char  <= 1'b0;
      s1_right <= 1'b0;
      s1_left  <= 1'b0;
      s1_top   <= 1'b0;
      s1_cube  <= '0;
    end else begin
      s1_char  <= char_c;
      s1_right <= right_c;
      s1_left  <= left_c;
      s1_top   <= top_c;
      s1_cube  <= cube_c;
    end
  end

  // ---------------------------------------------------------------------
  // Pixel pipeline, stage 2: colour priority and output register
  // ---------------------------------------------------------------------
  logic [23:0] rgb_c;

  always_comb begin
    rgb_c = BG_RGB;
    if (s1_char)
      rgb_c = CHAR_RGB;
    else if (s1_right)
      rgb_c = RIGHT_RGB;
    else if (s1_left)
      rgb_c = LEFT_RGB;
    else if (s1_top)
      rgb_c = palette(3'(color_idx[s1_cube]));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      menu_RGB <= BG_RGB;
    else
      menu_RGB <= rgb_c;
  end

endmodule

// File: tb/tb_menu_hop_row.sv
// tb_menu_hop_row: directed bench for menu_hop_row.
// Three instances share one stimulus stream:
//   dut_a: default colours (5 steps, saturating)
//   dut_b: 2 colours, saturating
//   dut_c: 2 colours, wrapping
// All instances use a 4-cycle motion tick, so one hop lasts 400*4+1 cycles.
module tb_menu_hop_row;

  localparam logic [23:0] BG    = 24'h92A5D8;
  localparam logic [23:0] CHR   = 24'hD85F02;
  localparam logic [23:0] RIGHT = 24'h314646;
  localparam logic [23:0] LEFT  = 24'h56A998;
  localparam logic [23:0] P0    = 24'hDEDE00;
  localparam logic [23:0] P1    = 24'h5646EF;
  localparam logic [23:0] P2    = 24'h00FF40;
  localparam logic [23:0] P3    = 24'h84239C;
  localparam logic [23:0] P4    = 24'hAA0D28;
  localparam int HOP_CYC        = 400 * 4 + 1;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        JPulse;
  logic        dir;
  logic [10:0] x_cnt;
  logic [9:0]  y_cnt;

  logic [23:0] rgb_a, rgb_b, rgb_c;
  logic        busy_a, busy_b, busy_c;
  logic [1:0]  pos_a, pos_b, pos_c;
  logic        done_a, done_b, done_c;
  logic [2:0]  st_a, st_b, st_c;

  menu_hop_row #(.STEP_DIV_LOG2(2)) dut_a (
    .clk(clk), .reset(reset), .JPulse(JPulse), .dir(dir),
    .x_cnt(x_cnt), .y_cnt(y_cnt), .menu_RGB(rgb_a), .hop_busy(busy_a),
    .pos_idx(pos_a), .level_done(done_a), .state_dbg(st_a)
  );

  menu_hop_row #(.STEP_DIV_LOG2(2), .N_COLORS(2), .COLOR_WRAP(0)) dut_b (
    .clk(clk), .reset(reset), .JPulse(JPulse), .dir(dir),
    .x_cnt(x_cnt), .y_cnt(y_cnt), .menu_RGB(rgb_b), .hop_busy(busy_b),
    .pos_idx(pos_b), .level_done(done_b), .state_dbg(st_b)
  );

  menu_hop_row #(.STEP_DIV_LOG2(2), .N_COLORS(2), .COLOR_WRAP(1)) dut_c (
    .clk(clk), .reset(reset), .JPulse(JPulse), .dir(dir),
    .x_cnt(x_cnt), .y_cnt(y_cnt), .menu_RGB(rgb_c), .hop_busy(busy_c),
    .pos_idx(pos_c), .level_done(done_c), .state_dbg(st_c)
  );

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  // Drive a pixel coordinate and compare all three RGB outputs two clocks later.
  task automatic probe(input string tag, input int x, input int y,
                       input logic [23:0] ea, input logic [23:0] eb, input logic [23:0] ec);
    @(negedge clk);
    x_cnt = 11'(x);
    y_cnt = 10'(y);
    exp_q.push_back(32'(ea));
    exp_q.push_back(32'(eb));
    exp_q.push_back(32'(ec));
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_a"}, 32'(rgb_a), exp_q.pop_front());
    check_eq({tag, "_b"}, 32'(rgb_b), exp_q.pop_front());
    check_eq({tag, "_c"}, 32'(rgb_c), exp_q.pop_front());
  endtask

  // Issue a hop request and measure hop_busy length in cycles.
  // mid_at > 0 injects an extra opposite-direction JPulse at that cycle.
  task automatic hop(input logic d, input int mid_at, output int dur);
    @(negedge clk);
    JPulse = 1'b1;
    dir    = d;
    @(negedge clk);
    JPulse = 1'b0;
    dur    = 0;
    while (busy_a && dur < 5000) begin
      dur++;
      if (dur == mid_at) begin
        JPulse = 1'b1;
        dir    = ~d;
      end else begin
        JPulse = 1'b0;
      end
      @(negedge clk);
    end
    JPulse = 1'b0;
  endtask

  // Pulse a request that must be refused; busy must never rise.
  task automatic bad_request(input string tag, input logic d, input logic [1:0] exp_pos);
    logic seen_busy;
    seen_busy = 1'b0;
    @(negedge clk);
    JPulse = 1'b1;
    dir    = d;
    @(negedge clk);
    JPulse = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (busy_a || busy_b || busy_c) seen_busy = 1'b1;
      @(negedge clk);
    end
    check_eq({tag, "_busy"}, 32'(seen_busy), 32'd0);
    check_eq({tag, "_pos"},  32'(pos_a), 32'(exp_pos));
  endtask

  initial begin
    int dur;
    reset  = 1'b0;
    JPulse = 1'b0;
    dir    = 1'b0;
    x_cnt  = '0;
    y_cnt  = '0;
    repeat (3) @(negedge clk);

    // reset state
    check_eq("rst_busy",  32'(busy_a), 32'd0);
    check_eq("rst_pos",   32'(pos_a),  32'd0);
    check_eq("rst_done",  32'(done_b), 32'd0);
    check_eq("rst_rgb",   32'(rgb_a),  32'(BG));
    check_eq("rst_state", 32'(st_a),   32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // static picture at rest on cube 0
    probe("char0",     350, 210, CHR,   CHR,   CHR);
    probe("c1_centre", 350, 410, P0,    P0,    P0);
    probe("bg",        0,   0,   BG,    BG,    BG);
    probe("right0",    420, 150, RIGHT, RIGHT, RIGHT);
    probe("left0",     440, 260, LEFT,  LEFT,  LEFT);
    probe("edge01",    400, 310, RIGHT, RIGHT, RIGHT);

    // off the -y end
    bad_request("bad_low", 1'b1, 2'd0);

    // hop 1: 0 -> 1
    hop(1'b0, 0, dur);
    check_eq("hop1_len", 32'(dur), 32'(HOP_CYC));
    check_eq("hop1_pos", 32'(pos_a), 32'd1);
    probe("hop1_char", 350, 410, CHR, CHR, CHR);
    probe("hop1_c1",   350, 480, P1,  P1,  P1);
    probe("hop1_c0",   350, 210, P0,  P0,  P0);
    check_eq("hop1_done_b", 32'(done_b), 32'd0);

    // hop 2: 1 -> 0 with an ignored mid-hop request
    hop(1'b1, 700, dur);
    check_eq("hop2_len", 32'(dur), 32'(HOP_CYC));
    check_eq("hop2_pos", 32'(pos_a), 32'd0);
    probe("hop2_c0", 350, 280, P1, P1, P1);

    // hop 3: 0 -> 1, second landing on cube 1
    hop(1'b0, 0, dur);
    check_eq("hop3_pos", 32'(pos_c), 32'd1);
    probe("hop3_c1", 350, 480, P2, P1, P0);

    // hops 4,5: -> 2 -> 3, every cube now visited
    hop(1'b0, 0, dur);
    check_eq("hop4_done_b", 32'(done_b), 32'd0);
    hop(1'b0, 0, dur);
    check_eq("hop5_pos",    32'(pos_b), 32'd3);
    check_eq("hop5_done_b", 32'(done_b), 32'd1);
    check_eq("hop5_done_c", 32'(done_c), 32'd0);
    check_eq("hop5_done_a", 32'(done_a), 32'd0);

    // off the +y end
    bad_request("bad_high", 1'b0, 2'd3);

    // hops 6..8: 3 -> 2 -> 1 -> 2, wrap instance reaches all-final
    hop(1'b1, 0, dur);
    hop(1'b1, 0, dur);
    hop(1'b0, 0, dur);
    check_eq("hop8_done_c", 32'(done_c), 32'd1);
    check_eq("hop8_done_b", 32'(done_b), 32'd1);

    // hop 9: 2 -> 1, cube 1 wraps in dut_c
    hop(1'b1, 0, dur);
    check_eq("hop9_done_c", 32'(done_c), 32'd0);
    check_eq("hop9_done_b", 32'(done_b), 32'd1);
    check_eq("hop9_pos",    32'(pos_a),  32'd1);
    probe("hop9_c1", 350, 480, P4, P1, P0);
    probe("hop9_c2", 350, 680, P3, P1, P1);

    // reset during SLIDE
    @(negedge clk);
    JPulse = 1'b1;
    dir    = 1'b0;
    @(negedge clk);
    JPulse = 1'b0;
    repeat (600) @(negedge clk);
    check_eq("slide_state", 32'(st_a), 32'd2);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_busy",  32'(busy_a), 32'd0);
    check_eq("mid_rst_pos",   32'(pos_a),  32'd0);
    check_eq("mid_rst_done",  32'(done_b), 32'd0);
    check_eq("mid_rst_state", 32'(st_c),   32'd0);
    @(negedge clk);
    reset = 1'b1;
    probe("post_rst_c1",   350, 480, P0,  P0,  P0);
    probe("post_rst_char", 350, 210, CHR, CHR, CHR);
    hop(1'b0, 0, dur);
    check_eq("fresh_len", 32'(dur), 32'(HOP_CYC));
    check_eq("fresh_pos", 32'(pos_a), 32'd1);
    probe("fresh_c1", 350, 480, P1, P1, P1);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
